// File: rtl/branch_checkpoint_table.sv
`default_nettype none
// ============================================================================
// Module   : branch_checkpoint_table
// Brief    : Circular store of per-branch rename checkpoints (free-list head,
//            rename map, GHR, delay-slot flag). Correct resolutions free
//            entries out of order. A mispredict squashes the branch and all
//            younger checkpoints, then presents the saved state for one cycle.
// Options  : CKPT_STATS_EN adds saturating allocation / mispredict counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_checkpoint_table #(
    parameter int BRANCH_NUM             = 4,
    parameter int REG_NUM                = 32,
    parameter int PHYS_REG_NUM_INDEX     = 6,
    parameter int ACTIVE_LIST_SIZE_INDEX = 6,
    parameter int GHR_LEN                = 8,
    localparam int BN_IDX                = $clog2(BRANCH_NUM),
    localparam int PR_IDX                = PHYS_REG_NUM_INDEX,
    localparam int AL_IDX                = ACTIVE_LIST_SIZE_INDEX,
    localparam int MAP_W                 = REG_NUM * PHYS_REG_NUM_INDEX
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                alloc_req,
    input  logic [AL_IDX-1:0]   alloc_branch_id,
    input  logic                alloc_ds_valid,
    input  logic [PR_IDX-1:0]   alloc_free_head,
    input  logic [GHR_LEN-1:0]  alloc_ghr,
    input  logic [MAP_W-1:0]    alloc_rename_map,
    output logic                alloc_ready,
    output logic [BN_IDX-1:0]   alloc_idx,
    input  logic                resolve_valid,
    input  logic [AL_IDX-1:0]   resolve_branch_id,
    input  logic                resolve_miss,
    output logic                recover_valid,
    output logic [PR_IDX-1:0]   recover_free_head,
    output logic [MAP_W-1:0]    recover_rename_map,
    output logic [GHR_LEN-1:0]  recover_ghr,
    output logic                recover_ds_valid,
    output logic [BN_IDX:0]     occupancy,
`ifdef CKPT_STATS_EN
    output logic [15:0]         stat_alloc_cnt,
    output logic [15:0]         stat_miss_cnt,
`endif
    output logic                protocol_err
);

    localparam logic [BN_IDX-1:0] c_one = BN_IDX'(1);

    // Checkpoint storage: only the valid bits are reset, payload is don't-care
    logic [BRANCH_NUM-1:0] r_valid;
    logic [BRANCH_NUM-1:0] r_ds;
    logic [AL_IDX-1:0]     r_bid [BRANCH_NUM];
    logic [PR_IDX-1:0]     r_fh  [BRANCH_NUM];
    logic [GHR_LEN-1:0]    r_ghr [BRANCH_NUM];
    logic [MAP_W-1:0]      r_map [BRANCH_NUM];

    logic [BN_IDX-1:0]     r_wptr;
    logic [BN_IDX:0]       r_occ;
    logic                  r_err;
    logic                  r_rec_valid;

    logic [BRANCH_NUM-1:0] w_match;
    logic [BRANCH_NUM-1:0] w_squash;
    logic                  w_any_match;
    logic [BN_IDX-1:0]     w_m_idx;
    logic [BN_IDX-1:0]     w_span;
    logic                  w_ready;
    logic                  w_miss_req;
    logic                  w_miss_hit;
    logic                  w_fix;
    logic                  w_do_alloc;
    logic                  w_err_set;
    logic [BRANCH_NUM-1:0] w_valid_nxt;
    logic [BN_IDX-1:0]     w_wptr_nxt;
    logic [BN_IDX:0]       w_occ_nxt;

    assign w_ready     = ~r_valid[r_wptr];
    assign alloc_ready = w_ready;
    assign alloc_idx   = r_wptr;
    assign occupancy   = r_occ;
    assign protocol_err  = r_err;
    assign recover_valid = r_rec_valid;

    // Younger-range span: entries at circular distance 0..(wptr-m-1) from m.
    // With a full table and m == wptr this wraps to BRANCH_NUM-1, i.e. all.
    assign w_span = r_wptr - w_m_idx - c_one;

    generate
        for (genvar gi = 0; gi < BRANCH_NUM; gi++) begin : g_slot
            assign w_match[gi]  = r_valid[gi] && (r_bid[gi] == resolve_branch_id);
            assign w_squash[gi] = (BN_IDX'(gi) - w_m_idx) <= w_span;
        end
    endgenerate

    assign w_any_match = |w_match;

    // Priority pick of the lowest-indexed matching checkpoint
    always_comb begin
        w_m_idx = '0;
        for (int i = BRANCH_NUM - 1; i >= 0; i--) begin
            if (w_match[i]) w_m_idx = BN_IDX'(i);
        end
    end

    // Event decode: flush dominates, a mispredict drops any same-cycle alloc
    always_comb begin
        w_miss_req = resolve_valid && resolve_miss;
        w_miss_hit = !flush && w_miss_req && w_any_match;
        w_fix      = !flush && resolve_valid && !resolve_miss;
        w_do_alloc = !flush && !w_miss_req && alloc_req && w_ready;
        w_err_set  = !flush && ((alloc_req && !w_ready && !w_miss_req) ||
                                (resolve_valid && !w_any_match));
    end

    // Next table state and occupancy
    always_comb begin
        w_valid_nxt = r_valid;
        w_wptr_nxt  = r_wptr;
        if (flush) begin
            w_valid_nxt = '0;
            w_wptr_nxt  = '0;
        end else if (w_miss_hit) begin
            w_valid_nxt = r_valid & ~w_squash;
            w_wptr_nxt  = w_m_idx + c_one;
        end else begin
            if (w_fix) w_valid_nxt = w_valid_nxt & ~w_match;
            if (w_do_alloc) begin
                w_valid_nxt[r_wptr] = 1'b1;
                w_wptr_nxt          = r_wptr + c_one;
            end
        end
        w_occ_nxt = '0;
        for (int i = 0; i < BRANCH_NUM; i++) begin
            w_occ_nxt = w_occ_nxt + (BN_IDX+1)'(w_valid_nxt[i]);
        end
    end

    // Control state: valid bits, pointer, occupancy, error and recover pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid            <= '0;
            r_wptr             <= '0;
            r_occ              <= '0;
            r_err              <= 1'b0;
            r_rec_valid        <= 1'b0;
            recover_free_head  <= '0;
            recover_rename_map <= '0;
            recover_ghr        <= '0;
            recover_ds_valid   <= 1'b0;
        end else begin
            r_valid     <= w_valid_nxt;
            r_wptr      <= w_wptr_nxt;
            r_occ       <= w_occ_nxt;
            r_rec_valid <= w_miss_hit;
            if (w_err_set) r_err <= 1'b1;
            if (w_miss_hit) begin
                recover_free_head  <= r_fh[w_m_idx];
                recover_rename_map <= r_map[w_m_idx];
                recover_ghr        <= {r_ghr[w_m_idx][GHR_LEN-1:1], ~r_ghr[w_m_idx][0]};
                recover_ds_valid   <= r_ds[w_m_idx];
            end
        end
    end

    // Checkpoint payload capture at the write pointer
    always_ff @(posedge clk) begin
        if (w_do_alloc) begin
            r_bid[r_wptr] <= alloc_branch_id;
            r_ds[r_wptr]  <= alloc_ds_valid;
            r_fh[r_wptr]  <= alloc_free_head;
            r_ghr[r_wptr] <= alloc_ghr;
            r_map[r_wptr] <= alloc_rename_map;
        end
    end

`ifdef CKPT_STATS_EN
    logic [15:0] r_stat_alloc;
    logic [15:0] r_stat_miss;

    assign stat_alloc_cnt = r_stat_alloc;
    assign stat_miss_cnt  = r_stat_miss;

    // Saturating event counters, untouched by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_alloc <= '0;
            r_stat_miss  <= '0;
        end else begin
            if (w_do_alloc && (r_stat_alloc != 16'hFFFF)) r_stat_alloc <= r_stat_alloc + 16'd1;
            if (w_miss_hit && (r_stat_miss != 16'hFFFF))  r_stat_miss  <= r_stat_miss + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_checkpoint_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_checkpoint_table
// Brief    : Directed vector table plus hand sequences for the checkpoint
//            table: fill/overflow, out-of-order frees, mispredict restore,
//            wrap-around squash, event priority and async reset mid-pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_checkpoint_table;

    localparam int c_map_w = 32 * 6;

    logic                clk;
    logic                rst;
    logic                flush;
    logic                alloc_req;
    logic [5:0]          alloc_branch_id;
    logic                alloc_ds_valid;
    logic [5:0]          alloc_free_head;
    logic [7:0]          alloc_ghr;
    logic [c_map_w-1:0]  alloc_rename_map;
    logic                alloc_ready;
    logic [1:0]          alloc_idx;
    logic                resolve_valid;
    logic [5:0]          resolve_branch_id;
    logic                resolve_miss;
    logic                recover_valid;
    logic [5:0]          recover_free_head;
    logic [c_map_w-1:0]  recover_rename_map;
    logic [7:0]          recover_ghr;
    logic                recover_ds_valid;
    logic [2:0]          occupancy;
    logic                protocol_err;
`ifdef CKPT_STATS_EN
    logic [15:0]         stat_alloc_cnt;
    logic [15:0]         stat_miss_cnt;
`endif

    int total = 0;
    int bad   = 0;

    branch_checkpoint_table dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .alloc_req          (alloc_req),
        .alloc_branch_id    (alloc_branch_id),
        .alloc_ds_valid     (alloc_ds_valid),
        .alloc_free_head    (alloc_free_head),
        .alloc_ghr          (alloc_ghr),
        .alloc_rename_map   (alloc_rename_map),
        .alloc_ready        (alloc_ready),
        .alloc_idx          (alloc_idx),
        .resolve_valid      (resolve_valid),
        .resolve_branch_id  (resolve_branch_id),
        .resolve_miss       (resolve_miss),
        .recover_valid      (recover_valid),
        .recover_free_head  (recover_free_head),
        .recover_rename_map (recover_rename_map),
        .recover_ghr        (recover_ghr),
        .recover_ds_valid   (recover_ds_valid),
        .occupancy          (occupancy),
`ifdef CKPT_STATS_EN
        .stat_alloc_cnt     (stat_alloc_cnt),
        .stat_miss_cnt      (stat_miss_cnt),
`endif
        .protocol_err       (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic       ar;
        logic [5:0] aid;
        logic [7:0] ghr;
        logic       rv;
        logic [5:0] rid;
        logic       rm;
        logic [2:0] occ;
        logic       rdy;
        logic [1:0] idx;
        logic       err;
        logic       rec;
    } vec_t;

    vec_t vecs [10];

    // Distinct, id-derived rename map so a restored map identifies its source
    function automatic logic [c_map_w-1:0] mk_map(input logic [5:0] id);
        logic [c_map_w-1:0] m;
        m = '0;
        for (int r = 0; r < 32; r++) m[r*6 +: 6] = id + 6'(r);
        return m;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; inputs return to idle just after the edge
    task automatic cyc(input logic fl, input logic ar, input logic [5:0] aid, input logic [7:0] ghr,
                       input logic rv, input logic [5:0] rid, input logic rm);
        flush             = fl;
        alloc_req         = ar;
        alloc_branch_id   = aid;
        alloc_ds_valid    = aid[0];
        alloc_free_head   = aid + 6'd1;
        alloc_ghr         = ghr;
        alloc_rename_map  = mk_map(aid);
        resolve_valid     = rv;
        resolve_branch_id = rid;
        resolve_miss      = rm;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        alloc_req     = 1'b0;
        resolve_valid = 1'b0;
        resolve_miss  = 1'b0;
    endtask

    task automatic alloc(input logic [5:0] id, input logic [7:0] ghr);
        cyc(1'b0, 1'b1, id, ghr, 1'b0, 6'd0, 1'b0);
    endtask

    task automatic resolve(input logic [5:0] id, input logic miss);
        cyc(1'b0, 1'b0, 6'd0, 8'd0, 1'b1, id, miss);
    endtask

    task automatic state(input string tag, input logic [2:0] occ, input logic rdy,
                         input logic [1:0] idx, input logic err, input logic rec);
        chk({tag, ".occupancy"},     occupancy,     occ);
        chk({tag, ".alloc_ready"},   alloc_ready,   rdy);
        chk({tag, ".alloc_idx"},     alloc_idx,     idx);
        chk({tag, ".protocol_err"},  protocol_err,  err);
        chk({tag, ".recover_valid"}, recover_valid, rec);
    endtask

    task automatic recover(input string tag, input logic [5:0] id, input logic [7:0] ghr_exp);
        chk({tag, ".recover_ghr"},  recover_ghr,        ghr_exp);
        chk({tag, ".recover_fh"},   recover_free_head,  id + 6'd1);
        chk({tag, ".recover_ds"},   recover_ds_valid,   id[0]);
        chk({tag, ".recover_map"},  recover_rename_map, mk_map(id));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; alloc_req = 1'b0; alloc_branch_id = '0; alloc_ds_valid = 1'b0;
        alloc_free_head = '0; alloc_ghr = '0; alloc_rename_map = '0;
        resolve_valid = 1'b0; resolve_branch_id = '0; resolve_miss = 1'b0;

        //          fl ar aid   ghr    rv rid   rm  occ  rdy idx err rec
        vecs[0] = '{0, 1, 6'd3,  8'h11, 0, 6'd0,  0, 3'd1, 1, 2'd1, 0, 0};
        vecs[1] = '{0, 1, 6'd7,  8'h5A, 0, 6'd0,  0, 3'd2, 1, 2'd2, 0, 0};
        vecs[2] = '{0, 1, 6'd9,  8'h33, 0, 6'd0,  0, 3'd3, 1, 2'd3, 0, 0};
        vecs[3] = '{0, 1, 6'd12, 8'h44, 0, 6'd0,  0, 3'd4, 0, 2'd0, 0, 0};
        vecs[4] = '{0, 1, 6'd20, 8'h55, 0, 6'd0,  0, 3'd4, 0, 2'd0, 1, 0};
        vecs[5] = '{0, 0, 6'd0,  8'h00, 1, 6'd7,  0, 3'd3, 0, 2'd0, 1, 0};
        vecs[6] = '{0, 0, 6'd0,  8'h00, 1, 6'd3,  0, 3'd2, 1, 2'd0, 1, 0};
        vecs[7] = '{0, 1, 6'd15, 8'h66, 1, 6'd9,  0, 3'd2, 1, 2'd1, 1, 0};
        vecs[8] = '{0, 0, 6'd0,  8'h00, 1, 6'd40, 0, 3'd2, 1, 2'd1, 1, 0};
        vecs[9] = '{0, 0, 6'd0,  8'h00, 0, 6'd0,  0, 3'd2, 1, 2'd1, 1, 0};

        do_reset();
        state("reset", 3'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("reset.recover_ghr", recover_ghr, 8'h00);

        for (int v = 0; v < 10; v++) begin
            cyc(vecs[v].fl, vecs[v].ar, vecs[v].aid, vecs[v].ghr,
                vecs[v].rv, vecs[v].rid, vecs[v].rm);
            state($sformatf("vec%0d", v), vecs[v].occ, vecs[v].rdy, vecs[v].idx,
                  vecs[v].err, vecs[v].rec);
        end

        // Mispredict restore of a middle checkpoint
        do_reset();
        alloc(6'd3, 8'h11);
        alloc(6'd7, 8'h5A);
        alloc(6'd9, 8'h33);
        alloc(6'd12, 8'h44);
        resolve(6'd7, 1'b1);
        state("miss7", 3'd1, 1'b1, 2'd2, 1'b0, 1'b1);
        recover("miss7", 6'd7, 8'h5B);
        cyc(1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);
        state("miss7_after", 3'd1, 1'b1, 2'd2, 1'b0, 1'b0);
        chk("miss7_after.recover_ghr_hold", recover_ghr, 8'h5B);

        // Wrap-around: A at idx3, B at idx0, mispredict A squashes both
        resolve(6'd3, 1'b0);
        alloc(6'd20, 8'h20);
        state("wrap_fill", 3'd1, 1'b1, 2'd3, 1'b0, 1'b0);
        alloc(6'd21, 8'h81);
        state("wrap_a", 3'd2, 1'b1, 2'd0, 1'b0, 1'b0);
        alloc(6'd22, 8'h22);
        state("wrap_b", 3'd3, 1'b1, 2'd1, 1'b0, 1'b0);
        resolve(6'd21, 1'b1);
        state("wrap_miss", 3'd1, 1'b1, 2'd0, 1'b0, 1'b1);
        recover("wrap_miss", 6'd21, 8'h80);

        // Mispredict with same-cycle alloc, then flush over a mispredict
        do_reset();
        alloc(6'd3, 8'h11);
        alloc(6'd7, 8'h5A);
        alloc(6'd9, 8'h33);
        cyc(1'b0, 1'b1, 6'd50, 8'hAA, 1'b1, 6'd9, 1'b1);
        state("miss_alloc", 3'd2, 1'b1, 2'd3, 1'b0, 1'b1);
        recover("miss_alloc", 6'd9, 8'h32);
        cyc(1'b1, 1'b0, 6'd0, 8'h00, 1'b1, 6'd7, 1'b1);
        state("flush_miss", 3'd0, 1'b1, 2'd0, 1'b0, 1'b0);

        // Full table, mispredict the oldest at write_ptr: everything squashed
        alloc(6'd1, 8'h01);
        alloc(6'd2, 8'h02);
        alloc(6'd4, 8'h04);
        alloc(6'd5, 8'h05);
        state("full", 3'd4, 1'b0, 2'd0, 1'b0, 1'b0);
        resolve(6'd1, 1'b1);
        state("full_miss", 3'd0, 1'b1, 2'd1, 1'b0, 1'b1);
        chk("full_miss.recover_ghr", recover_ghr, 8'h00);

        // Async reset during the recover pulse
        do_reset();
        alloc(6'd3, 8'h11);
        alloc(6'd7, 8'h5A);
        resolve(6'd7, 1'b1);
        chk("rstmid.pulse", recover_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        state("rstmid", 3'd0, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("rstmid.recover_ghr", recover_ghr, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 6'd0, 8'd0, 1'b0, 6'd0, 1'b0);
        state("rstmid_after", 3'd0, 1'b1, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_checkpoint_table.md
Name: branch_checkpoint_table

Overview:
- Writer side of the branch-state snapshot store.
- At rename, each branch captures a checkpoint: free-list head, architectural-to-physical rename map, GHR, active-list branch_id and delay-slot flag. The checkpoint goes into a circular table of BRANCH_NUM entries.
- Correct resolutions free entries. A misprediction truncates the table and, one cycle later, presents the saved state for restore.

Parameters:
- BRANCH_NUM, 4, checkpoint entries (power of 2); BN_IDX = log2(BRANCH_NUM).
- REG_NUM, 32, architectural registers.
- PHYS_REG_NUM_INDEX, 6, physical register index width (PR_IDX).
- ACTIVE_LIST_SIZE_INDEX, 6, active-list index width (AL_IDX).
- GHR_LEN, 8, global history width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  full pipeline flush; clears table
- alloc_req  in  1  branch renamed this cycle; capture checkpoint
- alloc_branch_id  in  AL_IDX  active-list id of branch
- alloc_ds_valid  in  1  branch delay slot already in active list
- alloc_free_head  in  PR_IDX  free-list head after branch
- alloc_ghr  in  GHR_LEN  GHR including this branch's prediction in bit 0
- alloc_rename_map  in  REG_NUM*PR_IDX  flattened rename map, reg r at [r*PR_IDX +: PR_IDX]
- alloc_ready  out  1  entry at write pointer free (combinational)
- alloc_idx  out  BN_IDX  current write pointer
- resolve_valid  in  1  branch resolved this cycle
- resolve_branch_id  in  AL_IDX  id of resolved branch
- resolve_miss  in  1  resolution was a misprediction
- recover_valid  out  1  one-cycle pulse, restore fields valid
- recover_free_head  out  PR_IDX  saved free head
- recover_rename_map  out  REG_NUM*PR_IDX  saved map
- recover_ghr  out  GHR_LEN  saved GHR with bit 0 inverted
- recover_ds_valid  out  1  saved delay-slot flag
- occupancy  out  BN_IDX+1  number of valid entries
- protocol_err  out  1  sticky error flag
- stat_alloc_cnt  out  16  CKPT_STATS_EN only
- stat_miss_cnt  out  16  CKPT_STATS_EN only

Behaviour:
- Reset (async, rst=1) clears:
  - all valid bits;
  - write_ptr=0 and occupancy=0;
  - protocol_err=0 and recover_valid=0;
  - all recover_* data outputs.
- Storage: per entry valid, branch_id, ds_valid, free_head, GHR, rename map. Payload is not reset; only valid is.
- alloc_ready = !valid[write_ptr]. alloc_idx = write_ptr.
- Allocation: if alloc_req && alloc_ready:
  - write all fields into entry write_ptr and set its valid;
  - write_ptr <= write_ptr+1, wrapping mod BRANCH_NUM.
- Allocation while not ready: no write and no pointer move; protocol_err <= 1.
- Correct resolve (resolve_valid && !resolve_miss): clear valid of every entry whose valid=1 and branch_id==resolve_branch_id. Entries free out of order; write_ptr does not move. No match: protocol_err <= 1.
- Mispredict (resolve_valid && resolve_miss):
  - m = lowest matching valid index.
  - Clear entry m and every entry at circular distance 1..(write_ptr-m-1) from m, i.e. all younger checkpoints.
  - write_ptr <= m+1.
  - Next cycle: recover_valid=1 and recover_* driven from entry m, with recover_ghr = {ghr[GHR_LEN-1:1], ~ghr[0]}.
  - No match: no table change, recover_valid stays 0, protocol_err <= 1.
- recover_valid is a one-cycle pulse. recover_* hold their last value otherwise.
- Simultaneous events, in priority order:
  - flush > mispredict > (correct resolve and alloc).
  - flush clears all valid, sets write_ptr=0 and suppresses recover_valid.
  - Mispredict with alloc_req in the same cycle: allocation dropped (younger path squashed), no error.
  - Correct resolve and alloc in the same cycle: both take effect. alloc_ready uses pre-update state.
- occupancy = popcount(valid), registered, updated with the table.
- Wrap-around: write_ptr=BRANCH_NUM-1 allocation wraps to 0. Younger-range computation is modulo BRANCH_NUM. With BRANCH_NUM entries valid and m = write_ptr, all entries are cleared.

Optional Feature:
- CKPT_STATS_EN defined:
  - stat_alloc_cnt increments per successful allocation;
  - stat_miss_cnt increments per matched mispredict;
  - both are 16-bit, saturate at 0xFFFF, reset to 0 and are unaffected by flush.
- Undefined: both ports and counters absent.

Test Plan:
- Reset, then 4 allocs with ids 3,7,9,12 -> occupancy=4, alloc_ready=0, alloc_idx=0; 5th alloc_req -> protocol_err=1, table unchanged.
- Correct resolve on id 7 -> entry 1 invalid, occupancy=3, alloc_ready still 0 (write_ptr=0 entry valid); resolve id 3 -> alloc_ready=1.
- Allocs with ids 3,7,9,12 and ghr of id 7 = 0x5A; mispredict on id 7 -> next cycle recover_valid=1, recover_ghr=0x5B, saved free_head/map match; occupancy=1, write_ptr=2.
- Wrap: write_ptr=3, allocate A (idx3), B (idx0); mispredict A -> idx3 and idx0 cleared, write_ptr=0.
- Same cycle: mispredict id 9 plus alloc_req -> no allocation, no protocol_err. Separately, same cycle: flush plus mispredict -> table empty, recover_valid=0.
- Assert rst mid-mispredict (cycle between miss and recover pulse) -> recover_valid=0 immediately, occupancy=0.
